// File: rtl/dlx_run_pkg.sv
// Shared definitions for the CPU run controller: FSM state encoding,
// stop-reason status codes and the program text base address.
package dlx_run_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } run_state_t;

  localparam logic [1:0] ST_NONE    = 2'b00;
  localparam logic [1:0] ST_LIMIT   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_BP      = 2'b11;

  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;

endpackage

// File: rtl/run_bp_cmp.sv
// Breakpoint comparators: per-channel PC match plus a lowest-index
// one-hot select of the matching channels.
module run_bp_cmp
  import dlx_run_pkg::*;
#(
  parameter int unsigned PC_W = 32,
  parameter int unsigned N_BP = 2
) (
  input  logic [PC_W-1:0]      i_pc,
  input  logic [N_BP*PC_W-1:0] i_bp_addr,
  input  logic [N_BP-1:0]      i_bp_valid,
  output logic                 o_hit,
  output logic [N_BP-1:0]      o_hit_onehot
);

  logic [N_BP-1:0] w_match;

  always_comb begin
    w_match = '0;
    for (int k = 0; k < int'(N_BP); k++) begin
      w_match[k] = i_bp_valid[k] & (i_pc == i_bp_addr[k*PC_W +: PC_W]);
    end
  end

  // x & -x isolates the lowest set bit, i.e. the lowest matching channel.
  assign o_hit_onehot = w_match & (~w_match + N_BP'(1));
  assign o_hit        = |w_match;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for a single-cycle CPU: init pulse, run with PC-limit,
// cycle-budget and (with RUN_CTRL_BP_EN defined) breakpoint stops.
module cpu_run_ctrl
  import dlx_run_pkg::*;
#(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned CNT_W       = 13,
  parameter int unsigned MAX_CYCLES  = 5000,
  parameter int unsigned INIT_CYCLES = 1,
  parameter int unsigned N_BP        = 2
) (
  input  logic                 clk,
  input  logic                 initPC,
  input  logic                 start,
  input  logic                 resume,
  input  logic [PC_W-1:0]      pc_lim,
  input  logic [PC_W-1:0]      pc_in,
  input  logic [N_BP*PC_W-1:0] bp_addr,
  input  logic [N_BP-1:0]      bp_valid,
  output logic                 cpu_init,
  output logic                 cpu_en,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           status,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [N_BP-1:0]      bp_hit
);

  localparam int unsigned INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  run_state_t       r_state;
  run_state_t       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_status;
  logic [N_BP-1:0]  r_bp_hit;
  logic             r_bp_mask;
  logic [INIT_W-1:0] r_init_cnt;

  logic            w_limit;
  logic            w_timeout;
  logic            w_bp;
  logic            w_stop;
  logic            w_run_en;
  logic            w_init_last;
  logic [N_BP-1:0] w_bp_onehot;

`ifdef RUN_CTRL_BP_EN
  logic w_bp_raw;

  run_bp_cmp #(
    .PC_W (PC_W),
    .N_BP (N_BP)
  ) u_bp_cmp (
    .i_pc         (pc_in),
    .i_bp_addr    (bp_addr),
    .i_bp_valid   (bp_valid),
    .o_hit        (w_bp_raw),
    .o_hit_onehot (w_bp_onehot)
  );

  // The first RUN cycle after resume sits on the breakpoint PC; skip it once.
  assign w_bp = w_bp_raw & ~r_bp_mask;
`else
  logic w_unused_bp;
  assign w_unused_bp = ^{bp_addr, bp_valid, r_bp_mask};
  assign w_bp        = 1'b0;
  assign w_bp_onehot = '0;
`endif

  assign w_limit     = (pc_in >= pc_lim);
  assign w_timeout   = (r_cnt == CNT_W'(MAX_CYCLES));
  assign w_stop      = w_limit | w_timeout | w_bp;
  assign w_run_en    = (r_state == S_RUN) & ~w_stop;
  assign w_init_last = (r_init_cnt == INIT_W'(INIT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (initPC) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_INIT;
      S_INIT:  if (w_init_last) w_next = S_RUN;
      S_RUN: begin
        if (w_limit | w_timeout) w_next = S_DONE;
        else if (w_bp)           w_next = S_PAUSE;
      end
      S_PAUSE: if (resume) w_next = S_RUN;
      S_DONE:  if (start) w_next = S_INIT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (initPC) begin
      r_cnt      <= '0;
      r_status   <= ST_NONE;
      r_bp_hit   <= '0;
      r_bp_mask  <= 1'b0;
      r_init_cnt <= '0;
    end else begin
      r_bp_mask <= (r_state == S_PAUSE) & resume;
      if (w_next == S_INIT) begin
        r_init_cnt <= (r_state == S_INIT) ? r_init_cnt + INIT_W'(1) : '0;
        r_cnt      <= '0;
        r_status   <= ST_NONE;
        r_bp_hit   <= '0;
      end else if (r_state == S_RUN) begin
        if (w_limit)        r_status <= ST_LIMIT;
        else if (w_timeout) r_status <= ST_TIMEOUT;
        else if (w_bp) begin
          r_status <= ST_BP;
          r_bp_hit <= w_bp_onehot;
        end
        if (w_run_en) r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    cpu_init = initPC | (r_state == S_INIT);
    cpu_en   = w_run_en;
    busy     = (r_state == S_INIT) | (r_state == S_RUN) | (r_state == S_PAUSE);
    done     = (r_state == S_DONE);
  end

  assign status      = r_status;
  assign cycle_count = r_cnt;
  assign bp_hit      = r_bp_hit;

endmodule
